// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction/PC FIFO between the memory response port and decode.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_w_i,
  input  logic               rst_w_i_l,
  input  logic               push_w_i_h,
  input  fetch_entry_t       push_entry_w_i,
  input  logic               pop_w_i_h,
  input  logic               flush_w_i_h,
  output fetch_entry_t       head_w_o,
  output logic               full_w_o_h,
  output logic               empty_w_o_h,
  output logic [CNT_W-1:0]   count_w_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_w_o_h  = (count_q == CNT_W'(DEPTH));
  assign empty_w_o_h = (count_q == '0);
  assign count_w_o   = count_q;
  assign head_w_o    = mem_q[rd_ptr_q];

  // Flush wins over push/pop; a push into a full buffer is only taken alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_w_i_h && !empty_w_o_h;
    do_push  = push_w_i_h && (!full_w_o_h || do_pop);
    if (flush_w_i_h) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry_w_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response buffering,
// and redirect flush with stale-response dropping.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_w_i,
  input  logic        rst_w_i_l,
  output logic        imem_req_w_o_h,
  output logic [31:0] imem_addr_w_o,
  input  logic        imem_gnt_w_i_h,
  input  logic        imem_rvalid_w_i_h,
  input  logic [31:0] imem_rdata_w_i,
  input  logic        redirect_w_i_h,
  input  logic [31:0] redirect_pc_w_i,
  input  logic        if_ready_w_i_h,
  output logic        if_valid_w_o_h,
  output logic [31:0] if_instr_w_o,
  output logic [31:0] if_pc_w_o,
  output logic [6:0]  if_opcode_w_o,
  output logic        misalign_w_o_h
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               misalign_q, misalign_d;

  logic               req_c, grant_c, keep_c, pop_c;
  logic [SUM_W-1:0]   credit_sum_c;
  fetch_entry_t       push_entry, head;
  logic               buf_full, buf_empty;
  logic [CNT_W-1:0]   buf_count;

  // Requests and buffered entries together never exceed the buffer depth.
  assign credit_sum_c = SUM_W'(out_q) + SUM_W'(buf_count);
  assign req_c   = (state_q == ST_RUN) && !buf_full && (credit_sum_c < SUM_W'(DEPTH));
  assign grant_c = req_c && imem_gnt_w_i_h;
  assign keep_c  = imem_rvalid_w_i_h && (drop_q == '0) && !redirect_w_i_h;
  assign pop_c   = !buf_empty && if_ready_w_i_h;

  assign push_entry.pc    = {pc_unused_guard(), 2'b00} | '0;
  assign push_entry.instr = imem_rdata_w_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_d      = out_q + CNT_W'(grant_c) - CNT_W'(imem_rvalid_w_i_h);
    drop_d     = drop_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (grant_c) begin
      pc_d = pc_q + PC_INC;
    end
    if (imem_rvalid_w_i_h && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
    // Everything still in flight after this edge belongs to the abandoned stream.
    if (redirect_w_i_h) begin
      pc_d   = {redirect_pc_w_i[31:2], 2'b00};
      drop_d = out_d;
      if (redirect_pc_w_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  // Response PC tracking: responses arrive in request order.
  logic [XLEN-1:0] rsp_pc_q [DEPTH];
  logic [XLEN-1:0] rsp_pc_d [DEPTH];
  logic [CNT_W-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;

  function automatic logic [CNT_W-1:0] slot_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(DEPTH - 1)) ? '0 : p + CNT_W'(1);
  endfunction

  function automatic logic [XLEN-3:0] pc_unused_guard();
    return rsp_pc_q[rsp_rd_q][XLEN-1:2];
  endfunction

  always_comb begin
    rsp_pc_d = rsp_pc_q;
    rsp_wr_d = rsp_wr_q;
    rsp_rd_d = rsp_rd_q;
    if (grant_c) begin
      rsp_pc_d[rsp_wr_q] = pc_q;
      rsp_wr_d           = slot_inc(rsp_wr_q);
    end
    if (imem_rvalid_w_i_h) begin
      rsp_rd_d = slot_inc(rsp_rd_q);
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rsp_pc_q[i] <= '0;
      end
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
    end else begin
      rsp_pc_q <= rsp_pc_d;
      rsp_wr_q <= rsp_wr_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .clk_w_i        (clk_w_i),
    .rst_w_i_l      (rst_w_i_l),
    .push_w_i_h     (keep_c),
    .push_entry_w_i (push_entry),
    .pop_w_i_h      (pop_c),
    .flush_w_i_h    (redirect_w_i_h),
    .head_w_o       (head),
    .full_w_o_h     (buf_full),
    .empty_w_o_h    (buf_empty),
    .count_w_o      (buf_count)
  );

  assign imem_req_w_o_h = req_c;
  assign imem_addr_w_o  = pc_q;
  assign if_valid_w_o_h = !buf_empty;
  assign if_instr_w_o   = head.instr;
  assign if_pc_w_o      = head.pc;
  assign if_opcode_w_o  = opcode_of(head.instr);
  assign misalign_w_o_h = misalign_q;

endmodule
